// File: rtl/mrij_ctrl.sv
// mrij_ctrl: multicycle Moore control FSM for the MIPS R/I/J datapath.
// Define MRIJ_CTRL_JAL_EN to decode jal (OP=000011) into a JAL state.
module mrij_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OP,
  input  logic [5:0] func,
  input  logic       ZF,
  output logic       PC_Write,
  output logic       IR_Write,
  output logic       Mem_Write,
  output logic       Write_Reg,
  output logic [1:0] w_r_s,
  output logic [1:0] wr_data_s,
  output logic       rs2_imm_s,
  output logic       imm_s,
  output logic [1:0] PC_s,
  output logic [2:0] ALU_OP,
  output logic       Instr_Done,
  output logic       Illegal
);
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC_R = 4'd3;
  localparam logic [3:0] S_EXEC_I = 4'd4;
  localparam logic [3:0] S_ADDR   = 4'd5;
  localparam logic [3:0] S_MEM_RD = 4'd6;
  localparam logic [3:0] S_MEM_WR = 4'd7;
  localparam logic [3:0] S_WB_R   = 4'd8;
  localparam logic [3:0] S_WB_I   = 4'd9;
  localparam logic [3:0] S_WB_LW  = 4'd10;
  localparam logic [3:0] S_BRANCH = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;
`ifdef MRIJ_CTRL_JAL_EN
  localparam logic [3:0] S_JAL    = 4'd13;
`endif
  localparam logic [2:0] A_AND = 3'b000;
  localparam logic [2:0] A_OR  = 3'b001;
  localparam logic [2:0] A_ADD = 3'b010;
  localparam logic [2:0] A_SUB = 3'b011;
  localparam logic [2:0] A_XOR = 3'b100;
  localparam logic [2:0] A_NOR = 3'b101;
  localparam logic [2:0] A_SLT = 3'b110;
  localparam logic [2:0] A_SLL = 3'b111;
  logic [3:0] state_q, state_d, dec_next;
  logic [2:0] r_alu, i_alu;
  logic       r_ok, i_sext;
  always_comb begin
    r_ok  = 1'b1;
    r_alu = A_AND;
    case (func)
      6'b100000: r_alu = A_ADD;
      6'b100010: r_alu = A_SUB;
      6'b100100: r_alu = A_AND;
      6'b100101: r_alu = A_OR;
      6'b100110: r_alu = A_XOR;
      6'b100111: r_alu = A_NOR;
      6'b101010: r_alu = A_SLT;
      6'b000000: r_alu = A_SLL;
      default:   r_ok  = 1'b0;
    endcase
  end
  always_comb begin
    i_alu  = OP == 6'b001000 ? A_ADD :
             OP == 6'b001100 ? A_AND :
             OP == 6'b001101 ? A_OR  :
             OP == 6'b001110 ? A_XOR : A_SLT;
    i_sext = OP == 6'b001000 || OP == 6'b001010;
  end
  // Unsupported encodings fall back to FETCH; DECODE flags them as Illegal.
  always_comb begin
    dec_next = S_FETCH;
    case (OP)
      6'b000000: dec_next = r_ok ? S_EXEC_R : S_FETCH;
      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010: dec_next = S_EXEC_I;
      6'b100011, 6'b101011: dec_next = S_ADDR;
      6'b000100, 6'b000101: dec_next = S_BRANCH;
      6'b000010: dec_next = S_JUMP;
`ifdef MRIJ_CTRL_JAL_EN
      6'b000011: dec_next = S_JAL;
`endif
      default:   dec_next = S_FETCH;
    endcase
  end
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = dec_next;
      S_EXEC_R: state_d = S_WB_R;
      S_EXEC_I: state_d = S_WB_I;
      S_ADDR:   state_d = OP == 6'b101011 ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: state_d = S_WB_LW;
      default:  state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  // Reset gating is combinational so no strobe leaks out in a reset cycle.
  always_comb begin
    {PC_Write, IR_Write, Mem_Write, Write_Reg, w_r_s, wr_data_s,
     rs2_imm_s, imm_s, PC_s, ALU_OP, Instr_Done, Illegal} = '0;
    case (state_q)
      S_FETCH: {IR_Write, PC_Write} = 2'b11;
      S_DECODE: Illegal = dec_next == S_FETCH;
      S_EXEC_R: ALU_OP = r_alu;
      S_WB_R: begin
        ALU_OP     = r_alu;
        Write_Reg  = 1'b1;
        w_r_s      = 2'b01;
        Instr_Done = 1'b1;
      end
      S_EXEC_I: {rs2_imm_s, imm_s, ALU_OP} = {1'b1, i_sext, i_alu};
      S_WB_I: begin
        {rs2_imm_s, imm_s, ALU_OP} = {1'b1, i_sext, i_alu};
        Write_Reg  = 1'b1;
        Instr_Done = 1'b1;
      end
      S_ADDR, S_MEM_RD: {rs2_imm_s, imm_s, ALU_OP} = {2'b11, A_ADD};
      S_MEM_WR: begin
        {rs2_imm_s, imm_s, ALU_OP} = {2'b11, A_ADD};
        Mem_Write  = 1'b1;
        Instr_Done = 1'b1;
      end
      S_WB_LW: begin
        Write_Reg  = 1'b1;
        wr_data_s  = 2'b01;
        Instr_Done = 1'b1;
      end
      S_BRANCH: begin
        ALU_OP     = A_SUB;
        PC_s       = 2'b01;
        PC_Write   = (OP == 6'b000100 && ZF) || (OP == 6'b000101 && !ZF);
        Instr_Done = 1'b1;
      end
      S_JUMP: {PC_Write, PC_s, Instr_Done} = {1'b1, 2'b10, 1'b1};
`ifdef MRIJ_CTRL_JAL_EN
      S_JAL: begin
        Write_Reg  = 1'b1;
        w_r_s      = 2'b10;
        wr_data_s  = 2'b10;
        PC_Write   = 1'b1;
        PC_s       = 2'b10;
        Instr_Done = 1'b1;
      end
`endif
      default: Illegal = 1'b0;
    endcase
    if (rst)
      {PC_Write, IR_Write, Mem_Write, Write_Reg, w_r_s, wr_data_s,
       rs2_imm_s, imm_s, PC_s, ALU_OP, Instr_Done, Illegal} = '0;
  end
endmodule

// File: tb/tb_mrij_ctrl.sv
// tb_mrij_ctrl: table, random and hand-sequence checks of mrij_ctrl against a per-instruction cycle model.
module tb_mrij_ctrl;
  logic clk = 1'b0, rst = 1'b1, ZF = 1'b0;
  logic [5:0] OP = '0, func = '0;
  logic PC_Write, IR_Write, Mem_Write, Write_Reg, rs2_imm_s, imm_s, Instr_Done, Illegal;
  logic [1:0] w_r_s, wr_data_s, PC_s;
  logic [2:0] ALU_OP;
  logic [16:0] got;
  int n_vec = 0, n_bad = 0;
  logic [16:0] eq[$];
  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zf;
    logic [16:0] last;
  } vec_t;
  vec_t tbl[$];
  mrij_ctrl dut (
    .clk(clk), .rst(rst), .OP(OP), .func(func), .ZF(ZF),
    .PC_Write(PC_Write), .IR_Write(IR_Write), .Mem_Write(Mem_Write),
    .Write_Reg(Write_Reg), .w_r_s(w_r_s), .wr_data_s(wr_data_s),
    .rs2_imm_s(rs2_imm_s), .imm_s(imm_s), .PC_s(PC_s), .ALU_OP(ALU_OP),
    .Instr_Done(Instr_Done), .Illegal(Illegal)
  );
  always #5 clk = ~clk;
  assign got = {PC_Write, IR_Write, Mem_Write, Write_Reg, w_r_s, wr_data_s,
                rs2_imm_s, imm_s, PC_s, ALU_OP, Instr_Done, Illegal};
  function automatic logic [16:0] ov(input int pcw, irw, mw, wr, wrs, wds, rsi, ims, pcs, alu, done, ill);
    return {pcw[0], irw[0], mw[0], wr[0], wrs[1:0], wds[1:0], rsi[0], ims[0],
            pcs[1:0], alu[2:0], done[0], ill[0]};
  endfunction
  localparam logic [16:0] V_F   = 17'h18000;
  localparam logic [16:0] V_Z   = 17'h00000;
  localparam logic [16:0] V_ILL = 17'h00001;
  task automatic chk(input logic [16:0] exp, input string nm);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %05h required %05h", nm, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Expected per-cycle outputs of one instruction, FETCH first.
  task automatic build(input logic [5:0] op, fn, input logic zf);
    int a;
    int sx;
    int ok;
    logic taken;
    eq.delete();
    eq.push_back(V_F);
    case (op)
      6'h00: begin
        ok = 1;
        a  = 0;
        case (fn)
          6'h20: a = 2;
          6'h22: a = 3;
          6'h24: a = 0;
          6'h25: a = 1;
          6'h26: a = 4;
          6'h27: a = 5;
          6'h2a: a = 6;
          6'h00: a = 7;
          default: ok = 0;
        endcase
        if (ok == 1) begin
          eq.push_back(V_Z);
          eq.push_back(ov(0,0,0,0,0,0,0,0,0,a,0,0));
          eq.push_back(ov(0,0,0,1,1,0,0,0,0,a,1,0));
        end else eq.push_back(V_ILL);
      end
      6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a: begin
        a  = op == 6'h08 ? 2 : op == 6'h0c ? 0 : op == 6'h0d ? 1 : op == 6'h0e ? 4 : 6;
        sx = (op == 6'h08 || op == 6'h0a) ? 1 : 0;
        eq.push_back(V_Z);
        eq.push_back(ov(0,0,0,0,0,0,1,sx,0,a,0,0));
        eq.push_back(ov(0,0,0,1,0,0,1,sx,0,a,1,0));
      end
      6'h23: begin
        eq.push_back(V_Z);
        eq.push_back(ov(0,0,0,0,0,0,1,1,0,2,0,0));
        eq.push_back(ov(0,0,0,0,0,0,1,1,0,2,0,0));
        eq.push_back(ov(0,0,0,1,0,1,0,0,0,0,1,0));
      end
      6'h2b: begin
        eq.push_back(V_Z);
        eq.push_back(ov(0,0,0,0,0,0,1,1,0,2,0,0));
        eq.push_back(ov(0,0,1,0,0,0,1,1,0,2,1,0));
      end
      6'h04, 6'h05: begin
        taken = op == 6'h04 ? zf : !zf;
        eq.push_back(V_Z);
        eq.push_back(ov(taken,0,0,0,0,0,0,0,1,3,1,0));
      end
      6'h02: begin
        eq.push_back(V_Z);
        eq.push_back(ov(1,0,0,0,0,0,0,0,2,0,1,0));
      end
`ifdef MRIJ_CTRL_JAL_EN
      6'h03: begin
        eq.push_back(V_Z);
        eq.push_back(ov(1,0,0,1,2,2,0,0,2,0,1,0));
      end
`endif
      default: eq.push_back(V_ILL);
    endcase
  endtask
  // Entered and left at posedge+1 with the FSM in FETCH; ZF is noise except in the final cycle.
  task automatic run(input logic [5:0] op, fn, input logic zf, input string nm, output logic [16:0] last);
    build(op, fn, zf);
    for (int i = 0; i < eq.size(); i++) begin
      OP   = op;
      func = fn;
      ZF   = (i == eq.size() - 1) ? zf : 1'($urandom);
      #1;
      chk(eq[i], $sformatf("%s op=%02h fn=%02h cyc%0d", nm, op, fn, i));
      last = got;
      tick();
    end
  endtask
  task automatic tadd(input logic [5:0] op, fn, input logic zf, input logic [16:0] last);
    vec_t v;
    v.op = op; v.fn = fn; v.zf = zf; v.last = last;
    tbl.push_back(v);
  endtask
  initial begin
    logic [16:0] last;
    logic [5:0] ops[12] = '{6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a,
                            6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0] fns[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h00};
    logic [5:0] rop, rfn;
    tadd(6'h00, 6'h20, 0, ov(0,0,0,1,1,0,0,0,0,2,1,0));
    tadd(6'h00, 6'h22, 1, ov(0,0,0,1,1,0,0,0,0,3,1,0));
    tadd(6'h00, 6'h27, 0, ov(0,0,0,1,1,0,0,0,0,5,1,0));
    tadd(6'h00, 6'h00, 0, ov(0,0,0,1,1,0,0,0,0,7,1,0));
    tadd(6'h00, 6'h21, 0, V_ILL);
    tadd(6'h08, 6'h15, 0, ov(0,0,0,1,0,0,1,1,0,2,1,0));
    tadd(6'h0c, 6'h00, 0, ov(0,0,0,1,0,0,1,0,0,0,1,0));
    tadd(6'h0d, 6'h00, 0, ov(0,0,0,1,0,0,1,0,0,1,1,0));
    tadd(6'h0e, 6'h00, 0, ov(0,0,0,1,0,0,1,0,0,4,1,0));
    tadd(6'h0a, 6'h00, 0, ov(0,0,0,1,0,0,1,1,0,6,1,0));
    tadd(6'h23, 6'h00, 0, ov(0,0,0,1,0,1,0,0,0,0,1,0));
    tadd(6'h2b, 6'h00, 0, ov(0,0,1,0,0,0,1,1,0,2,1,0));
    tadd(6'h04, 6'h00, 1, ov(1,0,0,0,0,0,0,0,1,3,1,0));
    tadd(6'h04, 6'h00, 0, ov(0,0,0,0,0,0,0,0,1,3,1,0));
    tadd(6'h05, 6'h00, 0, ov(1,0,0,0,0,0,0,0,1,3,1,0));
    tadd(6'h05, 6'h00, 1, ov(0,0,0,0,0,0,0,0,1,3,1,0));
    tadd(6'h02, 6'h00, 0, ov(1,0,0,0,0,0,0,0,2,0,1,0));
    tadd(6'h3f, 6'h00, 0, V_ILL);
`ifdef MRIJ_CTRL_JAL_EN
    tadd(6'h03, 6'h00, 0, ov(1,0,0,1,2,2,0,0,2,0,1,0));
`else
    tadd(6'h03, 6'h00, 0, V_ILL);
`endif
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk(V_Z, $sformatf("reset cyc%0d", i));
    end
    rst = 1'b0;
    #1;
    chk(V_Z, "idle after reset");
    tick();
    for (int i = 0; i < tbl.size(); i++) begin
      run(tbl[i].op, tbl[i].fn, tbl[i].zf, "table", last);
      n_vec++;
      if (last !== tbl[i].last) begin
        n_bad++;
        $display("FAIL table last state #%0d: got %05h required %05h", i, last, tbl[i].last);
      end
    end
    for (int i = 0; i < 300; i++) begin
      rop = $urandom_range(0, 14) > 11 ? 6'($urandom) : ops[$urandom_range(0, 11)];
      rfn = $urandom_range(0, 4) == 0 ? 6'($urandom) : fns[$urandom_range(0, 7)];
      run(rop, rfn, 1'($urandom), "random", last);
    end
    // Reset from a random point of an lw instruction.
    OP = 6'h23;
    repeat ($urandom_range(0, 3)) tick();
    rst = 1'b1;
    #1;
    chk(V_Z, "reset random state cyc0");
    for (int i = 1; i < 3; i++) begin
      tick();
      chk(V_Z, $sformatf("reset random state cyc%0d", i));
    end
    tick();
    rst = 1'b0;
    #1;
    chk(V_Z, "idle after random reset");
    tick();
    #1;
    chk(V_F, "first fetch after reset");
    // Reset landing in WB_LW must suppress the register write.
    #1;
    OP = 6'h23;
    build(6'h23, 6'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin
        #1;
        chk(eq[4], "wb_lw before reset");
      end
    end
    rst = 1'b1;
    #1;
    chk(V_Z, "wb_lw under reset");
    tick();
    rst = 1'b0;
    #1;
    chk(V_Z, "idle after wb_lw reset");
    tick();
    #1;
    chk(V_F, "fetch after wb_lw reset");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
